// File: rtl/fir_tap_pkg_streamer.sv
// fir_tap_pkg_streamer
// Reads coefficient words from a synchronous memory port and streams them to
// the FIR tap write bus as framed packets separated by idle gaps. A 2-entry
// skid FIFO absorbs the one-cycle read latency and downstream backpressure.
module fir_tap_pkg_streamer #(
  parameter int DATA_W   = 32,
  parameter int PKG_LEN  = 256,
  parameter int PKG_MAX  = 128,
  parameter int ADDR_W   = 15,
  parameter int PRE_GAP  = 100,
  parameter int POST_GAP = 100
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [7:0]        pkg_cnt_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              fir_tap_wr_cmd_o,
  output logic              fir_tap_wr_vld_o,
  output logic [DATA_W-1:0] fir_tap_wr_data_o,
  input  logic              fir_tap_wr_rdy_i,
  output logic [7:0]        pkg_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int GAP_MAX = (PRE_GAP > POST_GAP) ? PRE_GAP : POST_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int CNT_W   = $clog2(PKG_LEN + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE   = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_POST  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic [7:0]        pkg_idx_q, pkg_idx_d;
  logic [7:0]        pkg_cnt_q, pkg_cnt_d;
  logic              err_q, err_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       pop;
  logic       flush;
  logic       pre_last;
  logic       cnt_legal;
  logic       last_xfer;
  logic       rd_en;
  logic [2:0] pending;

  assign pop       = (fifo_cnt_q != 2'd0) && fir_tap_wr_rdy_i;
  assign flush     = abort_i && (state_q != ST_IDLE);
  assign pre_last  = (state_q == ST_PRE) && (gap_q == GAP_W'(PRE_GAP - 1));
  assign cnt_legal = (pkg_cnt_i != 8'd0) && (32'(pkg_cnt_i) <= 32'(PKG_MAX));
  assign last_xfer = pop && (xfer_cnt_q == CNT_W'(PKG_LEN - 1));
  // Words held or in flight after this cycle, counting a same-cycle pop.
  assign pending   = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);

  // The first read is launched in the last pre-gap cycle so that its word is
  // presented one cycle after the frame opens; the rest follow in BURST.
  assign rd_en = ((state_q == ST_BURST) || pre_last) &&
                 (rd_cnt_q < CNT_W'(PKG_LEN)) && (pending < 3'd2) && !abort_i;

  assign mem_rd_en_o       = rd_en;
  assign mem_rd_addr_o     = rd_en ? ADDR_W'(32'(pkg_idx_q) * 32'(PKG_LEN) + 32'(rd_cnt_q))
                                   : '0;
  assign fir_tap_wr_cmd_o  = (state_q == ST_BURST);
  assign fir_tap_wr_vld_o  = (fifo_cnt_q != 2'd0);
  assign fir_tap_wr_data_o = head_q;
  assign pkg_idx_o         = pkg_idx_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign done_o            = (state_q == ST_DONE);
  assign err_o             = err_q;

  // Skid FIFO: head_q is the presented word, tail_q the second entry.
  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = rd_en;
    case ({inflight_q, pop})
      2'b10: begin
        if (fifo_cnt_q == 2'd0) head_d = mem_rd_data_i;
        else                    tail_d = mem_rd_data_i;
        fifo_cnt_d = fifo_cnt_q + 2'd1;
      end
      2'b01: begin
        head_d     = tail_q;
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      2'b11: begin
        if (fifo_cnt_q == 2'd1) begin
          head_d = mem_rd_data_i;
        end else begin
          head_d = tail_q;
          tail_d = mem_rd_data_i;
        end
      end
      default: ;
    endcase
    if (flush) fifo_cnt_d = 2'd0;
  end

  // Sequencer: gaps, packet framing, packet indexing and abort handling.
  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    rd_cnt_d   = rd_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    pkg_idx_d  = pkg_idx_q;
    pkg_cnt_d  = pkg_cnt_q;
    err_d      = 1'b0;
    if (rd_en) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    if (pop)   xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          if (cnt_legal) begin
            state_d    = ST_PRE;
            pkg_cnt_d  = pkg_cnt_i;
            pkg_idx_d  = 8'd0;
            gap_d      = '0;
            rd_cnt_d   = '0;
            xfer_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_PRE: begin
        if (pre_last) begin
          state_d = ST_BURST;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_BURST: begin
        if (last_xfer) begin
          state_d    = ST_POST;
          rd_cnt_d   = '0;
          xfer_cnt_d = '0;
          gap_d      = '0;
        end
      end
      ST_POST: begin
        if (gap_q == GAP_W'(POST_GAP - 1)) begin
          gap_d = '0;
          if ((9'(pkg_idx_q) + 9'd1) < 9'(pkg_cnt_q)) begin
            pkg_idx_d = pkg_idx_q + 8'd1;
            state_d   = ST_PRE;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d    = ST_IDLE;
      gap_d      = '0;
      rd_cnt_d   = '0;
      xfer_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      rd_cnt_q   <= '0;
      xfer_cnt_q <= '0;
      pkg_idx_q  <= 8'd0;
      pkg_cnt_q  <= 8'd0;
      err_q      <= 1'b0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      rd_cnt_q   <= rd_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      pkg_idx_q  <= pkg_idx_d;
      pkg_cnt_q  <= pkg_cnt_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_pkg_streamer.sv
// Self-checking bench for fir_tap_pkg_streamer: memory model, transfer
// monitor and a reference of the expected packet stream and frame timing.
module tb_fir_tap_pkg_streamer;

  localparam int DATA_W   = 32;
  localparam int PKG_LEN  = 8;
  localparam int PKG_MAX  = 4;
  localparam int ADDR_W   = 5;
  localparam int PRE_GAP  = 4;
  localparam int POST_GAP = 4;
  localparam int MEM_SZ   = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic [7:0]        pkg_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              cmd;
  logic              vld;
  logic [DATA_W-1:0] wdata;
  logic              rdy;
  logic [7:0]        pkg_idx;
  logic              busy;
  logic              done;
  logic              err;

  fir_tap_pkg_streamer #(
    .DATA_W(DATA_W), .PKG_LEN(PKG_LEN), .PKG_MAX(PKG_MAX),
    .ADDR_W(ADDR_W), .PRE_GAP(PRE_GAP), .POST_GAP(POST_GAP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .pkg_cnt_i(pkg_cnt), .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr),
    .mem_rd_data_i(rd_data), .fir_tap_wr_cmd_o(cmd), .fir_tap_wr_vld_o(vld),
    .fir_tap_wr_data_o(wdata), .fir_tap_wr_rdy_i(rdy), .pkg_idx_o(pkg_idx),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DATA_W-1:0] mem [MEM_SZ];
  logic [DATA_W-1:0] got_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  int rise_q [$];
  int fall_q [$];
  int idx_q [$];
  int done_q [$];
  int idle_cyc = 0;
  int err_cnt = 0;
  int rd_total = 0;
  int start_cyc = 0;
  int outstanding = 0;
  logic cmd_prev = 1'b0;
  logic busy_prev = 1'b0;
  logic stall_prev = 1'b0;
  logic [DATA_W-1:0] data_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Synchronous memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= rd_en ? mem[rd_addr] : $urandom();
  end

  // Monitor sampled mid-cycle: records transfers, reads, frames and pulses.
  always @(negedge clk) begin
    if (vld && rdy) got_q.push_back(wdata);
    if (rd_en) begin
      addr_q.push_back(rd_addr);
      rd_total++;
    end
    if (cmd && !cmd_prev) begin
      rise_q.push_back(cyc);
      idx_q.push_back(int'(pkg_idx));
    end
    if (!cmd && cmd_prev) fall_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (err) err_cnt++;
    if (busy_prev && !busy) idle_cyc = cyc;
    if (stall_prev) begin
      chk("stall_vld_held", 32'(vld), 32'd1);
      chk("stall_data_held", wdata, data_prev);
    end
    if (rst || abort) outstanding = 0;
    else outstanding = outstanding + int'(rd_en) - int'(vld && rdy);
    if (rd_en) chk("occupancy_le_2", 32'(outstanding <= 2), 32'd1);
    stall_prev = vld && !rdy && !rst && !abort;
    data_prev  = wdata;
    cmd_prev   = cmd;
    busy_prev  = busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_cmd"}, 32'(cmd), 32'd0);
    chk({tag, "_vld"}, 32'(vld), 32'd0);
    chk({tag, "_data"}, wdata, 32'd0);
    chk({tag, "_pkg_idx"}, 32'(pkg_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic start_run(input logic [7:0] cnt);
    got_q.delete(); addr_q.delete(); rise_q.delete(); fall_q.delete();
    idx_q.delete(); done_q.delete();
    start = 1'b1;
    pkg_cnt = cnt;
    start_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  // mode 0: rdy high; 1: alternating with a 3-cycle low window; 2: random.
  // inject_at > 0 pulses start with pkg_cnt=0 at that loop step.
  task automatic wait_done(input int mode, input int budget, input int inject_at);
    int n = 0;
    int w = $urandom_range(8, 14);
    while (done_q.size() == 0 && n < budget) begin
      case (mode)
        1: rdy = (n >= w && n < w + 3) ? 1'b0 : ~n[0];
        2: rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      start = (inject_at > 0 && n == inject_at);
      if (start) pkg_cnt = 8'd0;
      tick();
      n++;
    end
    start = 1'b0;
    rdy = 1'b1;
    chk("run_done_pulses", 32'(done_q.size()), 32'd1);
    tick(); tick();
    chk("done_single", 32'(done_q.size()), 32'd1);
    chk("idle_after_run", 32'(busy), 32'd0);
  endtask

  // Reference stream: packet p word k comes from address p*PKG_LEN+k.
  task automatic check_stream(input int cnt);
    int total = cnt * PKG_LEN;
    chk("word_count", 32'(got_q.size()), 32'(total));
    chk("read_count", 32'(addr_q.size()), 32'(total));
    for (int i = 0; i < total; i++) begin
      if (i < got_q.size()) chk("word", got_q[i], mem[i % MEM_SZ]);
      if (i < addr_q.size()) chk("addr", 32'(addr_q[i]), 32'(i % MEM_SZ));
    end
  endtask

  // Frame timing: PRE_GAP after start, one latency cycle plus PKG_LEN words
  // per frame at full rate, POST+PRE between frames, done POST_GAP after.
  task automatic check_frames(input int cnt, input bit full_rate);
    chk("frame_count", 32'(rise_q.size()), 32'(cnt));
    chk("frame_end_count", 32'(fall_q.size()), 32'(cnt));
    if (rise_q.size() == cnt && fall_q.size() == cnt && cnt > 0) begin
      chk("first_frame_delay", 32'(rise_q[0] - start_cyc), 32'(1 + PRE_GAP));
      for (int i = 0; i < cnt; i++) begin
        chk("pkg_idx_at_frame", 32'(idx_q[i]), 32'(i));
        if (full_rate) chk("frame_len", 32'(fall_q[i] - rise_q[i]), 32'(PKG_LEN + 1));
        if (i > 0) chk("inter_frame_gap", 32'(rise_q[i] - fall_q[i-1]), 32'(POST_GAP + PRE_GAP));
      end
      if (done_q.size() > 0) begin
        chk("done_delay", 32'(done_q[0] - fall_q[cnt-1]), 32'(POST_GAP));
        chk("busy_fall", 32'(idle_cyc - done_q[0]), 32'd1);
      end
    end
  endtask

  task automatic wait_words(input int nwords, input int budget);
    int n = 0;
    while (got_q.size() < nwords && n < budget) begin
      tick();
      n++;
    end
    chk("reach_word", 32'(got_q.size() >= nwords), 32'd1);
  endtask

  initial begin
    int rd_before;
    int err_before;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pkg_cnt = 8'd0; rdy = 1'b0;
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 32'(i);
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    rdy = 1'b1;
    tick();

    // Basic two-packet run at full rate.
    start_run(8'd2);
    wait_done(0, 300, 0);
    check_stream(2);
    check_frames(2, 1'b1);

    // Backpressure with random coefficient contents.
    for (int i = 0; i < MEM_SZ; i++) mem[i] = $urandom();
    start_run(8'd1);
    wait_done(1, 300, 0);
    check_stream(1);
    check_frames(1, 1'b0);
    start_run(8'd3);
    wait_done(2, 600, 0);
    check_stream(3);
    check_frames(3, 1'b0);

    // Illegal starts.
    rd_before = rd_total;
    err_before = err_cnt;
    start = 1'b1; pkg_cnt = 8'd0;
    tick();
    start = 1'b0;
    chk("err_cnt0", 32'(err), 32'd1);
    chk("busy_cnt0", 32'(busy), 32'd0);
    tick();
    chk("err_cnt0_cleared", 32'(err), 32'd0);
    start = 1'b1; pkg_cnt = 8'(PKG_MAX + 1);
    tick();
    start = 1'b0;
    chk("err_cnt_max1", 32'(err), 32'd1);
    chk("busy_cnt_max1", 32'(busy), 32'd0);
    tick(); tick();
    chk("err_pulse_count", 32'(err_cnt - err_before), 32'd2);
    chk("no_reads_illegal", 32'(rd_total - rd_before), 32'd0);

    // Abort while the 4th word of the first packet is stalled.
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 32'(i);
    start_run(8'd2);
    wait_words(3, 100);
    rdy = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cmd", 32'(cmd), 32'd0);
    chk("abort_vld", 32'(vld), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rd_en", 32'(rd_en), 32'd0);
    chk("abort_words", 32'(got_q.size()), 32'd3);
    rdy = 1'b1;
    repeat (20) tick();
    chk("abort_no_done", 32'(done_q.size()), 32'd0);
    // Abort together with start in idle: start is ignored.
    abort = 1'b1; start = 1'b1; pkg_cnt = 8'd1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    chk("abort_start_err", 32'(err), 32'd0);
    tick();
    start_run(8'd1);
    wait_done(0, 300, 0);
    check_stream(1);
    check_frames(1, 1'b1);

    // Full-depth run; a mid-run start with an illegal count is ignored.
    for (int i = 0; i < MEM_SZ; i++) mem[i] = $urandom();
    err_before = err_cnt;
    start_run(8'(PKG_MAX));
    wait_done(0, 400, 30);
    check_stream(PKG_MAX);
    check_frames(PKG_MAX, 1'b1);
    chk("mid_run_start_no_err", 32'(err_cnt - err_before), 32'd0);
    chk("pkg_idx_held", 32'(pkg_idx), 32'(PKG_MAX - 1));

    // Reset at word 5, then the basic run again.
    for (int i = 0; i < MEM_SZ; i++) mem[i] = 32'(i);
    start_run(8'd2);
    wait_words(5, 100);
    rst = 1'b1;
    tick();
    check_all_zero("midreset");
    rst = 1'b0;
    tick();
    chk("midreset_idle", 32'(busy), 32'd0);
    start_run(8'd2);
    wait_done(0, 300, 0);
    check_stream(2);
    check_frames(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
